encod8to3_seq: RTL



---
 rtl/encod_pkg.sv | 27 ++
 rtl/encod_prio_comb.sv | 19 +
 rtl/encod8to3_seq.sv | 67 ++++++
 3 files changed

// File: rtl/encod_pkg.sv
// Shared constants and bit-vector helpers for the sequential 8-to-3 priority encoder.
// Helpers operate on a zero-extended VEC_MAX-bit vector so any N up to VEC_MAX can use them.
package encod_pkg;

  localparam int N_DEF   = 8;
  localparam int W_DEF   = 3;
  localparam int VEC_MAX = 256;

  function automatic int msb_index(input logic [VEC_MAX-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < VEC_MAX; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int popcount(input logic [VEC_MAX-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < VEC_MAX; i++) begin
      cnt = cnt + int'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encod_prio_comb.sv
// Combinational highest-index-first priority encoder: index of the top set bit plus a valid flag.
// The index reads 0 when no bit is set.
module encod_prio_comb
  import encod_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  always_comb begin
    idx_o = W'(msb_index(VEC_MAX'(vec_i)));
    vld_o = |vec_i;
  end

endmodule

// File: rtl/encod8to3_seq.sv
// Sequential 8-to-3 priority encoder: sticky pending vector drained one index per VALID&&READY.
// Optional sticky merge flag OVF is built when ENCOD_OVF_EN is defined.
module encod8to3_seq
  import encod_pkg::*;
#(
  parameter  int N = N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic [N-1:0] A,
  output logic [W-1:0] Y,
  output logic         VALID,
  input  logic         READY,
  output logic [N-1:0] PEND,
`ifdef ENCOD_OVF_EN
  output logic         OVF,
`endif
  output logic [W:0]   CNT
);

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] clr;
  logic [N-1:0] req;
  logic [W-1:0] y_idx;
  logic         y_vld;

  encod_prio_comb #(.N(N)) u_prio (
    .vec_i (pend_q),
    .idx_o (y_idx),
    .vld_o (y_vld)
  );

  // A bit cleared by the handshake and re-requested in the same cycle stays pending.
  always_comb begin
    clr    = (y_vld && READY) ? (N'(1) << y_idx) : '0;
    req    = EN ? A : '0;
    pend_d = (pend_q & ~clr) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

`ifdef ENCOD_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (|(req & pend_q & ~clr));
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;
`endif

  assign PEND  = pend_q;
  assign VALID = y_vld;
  assign Y     = y_idx;
  assign CNT   = (W+1)'(popcount(VEC_MAX'(pend_q)));

endmodule
